// File: rtl/ci_fir_pkg.sv
// Shared definitions for the FIR custom-instruction engine: opcodes, FSM states
// and the accumulator width helper.
package ci_fir_pkg;

    localparam logic [1:0] OP_LOAD_COEF = 2'd0;
    localparam logic [1:0] OP_PUSH      = 2'd1;
    localparam logic [1:0] OP_CLEAR     = 2'd2;
    localparam logic [1:0] OP_READ_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2
    } fir_state_e;

    // Width that holds TAPS full-precision products without overflow.
    function automatic int accWidth(input int dataW, input int coefW, input int taps);
        return dataW + coefW + $clog2(taps);
    endfunction

endpackage

// File: rtl/ci_fir_mac.sv
// Registered signed multiplier feeding an accumulator; accSum_o already includes
// the product currently held in the pipeline register.
module ci_fir_mac #(
    parameter int DATA_W = 9,
    parameter int COEF_W = 12,
    parameter int ACC_W  = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce_i,
    input  logic                     clear_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [ACC_W-1:0]  accSum_o
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod_q;
    logic                     prodValid_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  prodExt;

    assign prodExt  = prodValid_q ? {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q} : '0;
    assign accSum_o = acc_q + prodExt;

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q      <= '0;
            prodValid_q <= 1'b0;
            acc_q       <= '0;
        end else if (ce_i) begin
            if (clear_i) begin
                prod_q      <= '0;
                prodValid_q <= 1'b0;
                acc_q       <= '0;
            end else begin
                acc_q       <= accSum_o;
                prodValid_q <= en_i;
                if (en_i) begin
                    prod_q <= PROD_W'(sample_i) * PROD_W'(coef_i);
                end
            end
        end
    end

endmodule

// File: rtl/ci_fir_engine.sv
// Multi-cycle FIR custom instruction: coefficient bank, sample delay line and a
// sequential MAC walk; done is raised by the FSM when the datapath finishes.
module ci_fir_engine
    import ci_fir_pkg::*;
#(
    parameter int TAPS   = 16,
    parameter int DATA_W = 9,
    parameter int COEF_W = 12,
    parameter int SHIFT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en_i,
    input  logic        start_i,
    input  logic [1:0]  n_i,
    input  logic [31:0] dataa_i,
    input  logic [31:0] datab_i,
    output logic [31:0] result_o,
    output logic        done_o
);

    localparam int ACC_W = accWidth(DATA_W, COEF_W, TAPS);
    localparam int IDX_W = $clog2(TAPS);

    if (ACC_W > 32) begin : gAccTooWide
        $error("ci_fir_engine: accumulator width exceeds 32 bits");
    end
    if (TAPS < 2 || TAPS > 64) begin : gTapsRange
        $error("ci_fir_engine: TAPS must lie in 2..64");
    end

    fir_state_e               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [31:0]              result_q, result_d;
    logic [31:0]              last_q, last_d;
    logic                     done_q, done_d;
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [DATA_W-1:0] x_q [TAPS];

    logic                     loadCoef, pushSample, clearLine, macClear, macEn;
    logic                     coefIdxOk;
    logic signed [DATA_W-1:0] macSample;
    logic signed [COEF_W-1:0] macCoef;
    logic signed [ACC_W-1:0]  accSum;
    logic signed [ACC_W-1:0]  accShifted;
    logic [31:0]              finalResult;
    logic                     unusedBits;

    assign coefIdxOk   = datab_i < 32'(TAPS);
    assign macSample   = x_q[idx_q];
    assign macCoef     = coef_q[idx_q];
    assign accShifted  = accSum >>> SHIFT;
    assign finalResult = 32'(accShifted);
    assign result_o    = result_q;
    assign done_o      = done_q & clk_en_i;
    // Only the low operand bits carry a sample or coefficient.
    assign unusedBits  = ^dataa_i;

    ci_fir_mac #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .ACC_W (ACC_W)
    ) uMac (
        .clk     (clk),
        .reset   (reset),
        .ce_i    (clk_en_i),
        .clear_i (macClear),
        .en_i    (macEn),
        .sample_i(macSample),
        .coef_i  (macCoef),
        .accSum_o(accSum)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        result_d   = result_q;
        last_d     = last_q;
        done_d     = 1'b0;
        loadCoef   = 1'b0;
        pushSample = 1'b0;
        clearLine  = 1'b0;
        macClear   = 1'b0;
        macEn      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    case (n_i)
                        OP_LOAD_COEF: begin
                            done_d   = 1'b1;
                            loadCoef = coefIdxOk;
                            result_d = coefIdxOk ? 32'h0 : 32'hFFFF_FFFF;
                        end
                        OP_PUSH: begin
                            pushSample = 1'b1;
                            macClear   = 1'b1;
                            idx_d      = '0;
                            state_d    = MAC;
                        end
                        OP_CLEAR: begin
                            clearLine = 1'b1;
                            result_d  = 32'h0;
                            done_d    = 1'b1;
                        end
                        default: begin
                            result_d = last_q;
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            MAC: begin
                macEn = 1'b1;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(TAPS-1)) begin
                    state_d = FIN;
                end
            end
            // The final product is still in the multiplier register, so the
            // result is taken from the accumulator's running sum.
            FIN: begin
                result_d = finalResult;
                last_d   = finalResult;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            result_q <= '0;
            last_q   <= '0;
            done_q   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
                x_q[k]    <= '0;
            end
        end else if (clk_en_i) begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            last_q   <= last_d;
            done_q   <= done_d;
            if (loadCoef) begin
                coef_q[datab_i[IDX_W-1:0]] <= dataa_i[COEF_W-1:0];
            end
            if (pushSample) begin
                for (int k = TAPS-1; k > 0; k--) begin
                    x_q[k] <= x_q[k-1];
                end
                x_q[0] <= dataa_i[DATA_W-1:0];
            end else if (clearLine) begin
                for (int k = 0; k < TAPS; k++) begin
                    x_q[k] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ci_fir_engine.sv
// Scoreboard bench for ci_fir_engine: two DUTs (SHIFT=0 and SHIFT=4) share one
// stimulus stream and are checked against an arithmetic FIR model.
module tb_ci_fir_engine;
    import ci_fir_pkg::*;

    localparam int TAPS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clkEn;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result0, result4;
    logic        done0, done4;

    always #5 clk = ~clk;

    ci_fir_engine #(.TAPS(TAPS), .DATA_W(9), .COEF_W(12), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .clk_en_i(clkEn), .start_i(start), .n_i(n),
        .dataa_i(dataa), .datab_i(datab), .result_o(result0), .done_o(done0)
    );

    ci_fir_engine #(.TAPS(TAPS), .DATA_W(9), .COEF_W(12), .SHIFT(4)) dutShift (
        .clk(clk), .reset(reset), .clk_en_i(clkEn), .start_i(start), .n_i(n),
        .dataa_i(dataa), .datab_i(datab), .result_o(result4), .done_o(done4)
    );

    typedef struct {
        logic [31:0] exp0;
        logic [31:0] exp4;
        int          lat;
        int          rawLat;
        int          enStamp;
        int          rawStamp;
        string       name;
    } expect_t;

    expect_t sbQ[$];
    int      total = 0;
    int      bad = 0;
    int      enCyc = 0;
    int      rawCyc = 0;
    int      coefM [TAPS];
    int      xM [$];
    int      lastM = 0;

    always @(posedge clk) begin
        rawCyc <= rawCyc + 1;
        if (clkEn) enCyc <= enCyc + 1;
    end

    task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
        end
    endtask

    // Monitor: every delivered done pops one expectation and checks both DUTs.
    always @(negedge clk) begin
        if (!reset && (done0 || done4)) begin
            expect_t e;
            checkOutput("doneAgree", 32'(done4), 32'(done0));
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedDone", 32'(done0), 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput({e.name, " result"}, result0, e.exp0);
                checkOutput({e.name, " resultShift4"}, result4, e.exp4);
                checkOutput({e.name, " latency"}, 32'(enCyc - e.enStamp + 1), 32'(e.lat));
                checkOutput({e.name, " rawLatency"}, 32'(rawCyc - e.rawStamp + 1), 32'(e.rawLat));
            end
        end
    end

    task automatic clearModel(input logic clearCoef);
        xM.delete();
        for (int k = 0; k < TAPS; k++) begin
            xM.push_back(0);
            if (clearCoef) coefM[k] = 0;
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200 && sbQ.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("pendingAfterWait", 32'(sbQ.size()), 32'd0);
        sbQ.delete();
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int stallAt, input int stallLen, input string name);
        expect_t           e;
        int                acc;
        logic signed [11:0] c12;
        logic signed [8:0]  s9;
        waitIdle();
        start = 1'b1; n = op; dataa = a; datab = b;
        @(posedge clk); #1;
        start = 1'b0; n = 2'($urandom); dataa = $urandom; datab = $urandom;
        e.name = name;
        case (op)
            OP_LOAD_COEF: begin
                c12 = a[11:0];
                if (b < 32'(TAPS)) begin
                    coefM[b[1:0]] = int'(c12);
                    e.exp0 = 32'h0;
                end else begin
                    e.exp0 = 32'hFFFF_FFFF;
                end
                e.exp4 = e.exp0;
                e.lat  = 1;
            end
            OP_PUSH: begin
                s9 = a[8:0];
                xM.push_front(int'(s9));
                void'(xM.pop_back());
                acc = 0;
                for (int k = 0; k < TAPS; k++) acc += xM[k] * coefM[k];
                lastM  = acc;
                e.exp0 = 32'(acc);
                e.exp4 = 32'(acc >>> 4);
                e.lat  = TAPS + 2;
            end
            OP_CLEAR: begin
                clearModel(1'b0);
                e.exp0 = 32'h0;
                e.exp4 = 32'h0;
                e.lat  = 1;
            end
            default: begin
                e.exp0 = 32'(lastM);
                e.exp4 = 32'(lastM >>> 4);
                e.lat  = 1;
            end
        endcase
        e.rawLat   = e.lat + ((stallLen > 0 && stallAt <= e.lat - 1) ? stallLen : 0);
        e.enStamp  = enCyc;
        e.rawStamp = rawCyc;
        sbQ.push_back(e);
        if (stallLen > 0) begin
            repeat (stallAt) begin @(posedge clk); #1; end
            clkEn = 1'b0;
            repeat (stallLen) begin @(posedge clk); #1; end
            clkEn = 1'b1;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        sbQ.delete();
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        clearModel(1'b1);
        lastM = 0;
    endtask

    initial begin
        reset = 1'b1; clkEn = 1'b1; start = 1'b0; n = '0; dataa = '0; datab = '0;
        clearModel(1'b1);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
        checkOutput("resetResult", result0, 32'h0);
        checkOutput("resetDone", 32'(done0), 32'd0);

        // Basic filter: coefficients 1..4, samples 1,2,3.
        for (int k = 0; k < TAPS; k++) applyStimulus(OP_LOAD_COEF, 32'(k + 1), 32'(k), 0, 0, "loadBasic");
        for (int k = 1; k <= 3; k++) applyStimulus(OP_PUSH, 32'(k), $urandom, 0, 0, "pushBasic");
        waitIdle();
        checkOutput("basicLast", result0, 32'd10);

        // Reset while the MAC walk is in flight.
        applyStimulus(OP_PUSH, 32'd5, 32'd0, 0, 0, "pushAborted");
        repeat (2) begin @(posedge clk); #1; end
        doReset();
        checkOutput("midResetResult", result0, 32'h0);
        checkOutput("midResetResultShift4", result4, 32'h0);
        applyStimulus(OP_READ_LAST, 32'd0, 32'd0, 0, 0, "readAfterReset");
        applyStimulus(OP_PUSH, 32'd5, 32'd0, 0, 0, "pushAfterReset");

        // Signed extremes with junk in the ignored upper operand bits.
        for (int k = 0; k < TAPS; k++) applyStimulus(OP_LOAD_COEF, 32'hABCD_E800, 32'(k), 0, 0, "loadExtreme");
        for (int k = 0; k < TAPS; k++) applyStimulus(OP_PUSH, 32'h2468_AD00, 32'd0, 0, 0, "pushExtreme");
        waitIdle();
        checkOutput("extremeResult", result0, 32'h0020_0000);
        checkOutput("extremeResultShift4", result4, 32'd131072);

        // Out-of-range index, then clear.
        applyStimulus(OP_LOAD_COEF, 32'd77, 32'd7, 0, 0, "loadBadIdx");
        applyStimulus(OP_LOAD_COEF, 32'd77, 32'h0000_0101, 0, 0, "loadBadIdxWide");
        applyStimulus(OP_PUSH, 32'h0000_0055, 32'd0, 0, 0, "pushAfterBadIdx");
        applyStimulus(OP_CLEAR, $urandom, $urandom, 0, 0, "clear");
        applyStimulus(OP_PUSH, 32'd0, 32'd0, 0, 0, "pushZero");
        applyStimulus(OP_READ_LAST, 32'd0, 32'd0, 0, 0, "readAfterClear");

        // clk_en stalls: mid-MAC and in the would-be done cycle.
        for (int k = 0; k < TAPS; k++) applyStimulus(OP_LOAD_COEF, 32'(3 - 2 * k), 32'(k), 0, 0, "loadStall");
        applyStimulus(OP_PUSH, 32'd17, 32'd0, 0, 0, "pushPreStall");
        applyStimulus(OP_PUSH, 32'h0000_01F0, 32'd0, 2, 3, "pushStallMac");
        applyStimulus(OP_PUSH, 32'd9, 32'd0, TAPS + 1, 1, "pushStallDone");
        applyStimulus(OP_LOAD_COEF, 32'd6, 32'd1, 0, 2, "loadStallDone");

        // A start during MAC must be ignored.
        applyStimulus(OP_PUSH, 32'd33, 32'd0, 0, 0, "pushBusy");
        @(posedge clk); #1;
        start = 1'b1; n = OP_CLEAR;
        @(posedge clk); #1;
        start = 1'b0;
        applyStimulus(OP_PUSH, 32'd2, 32'd0, 0, 0, "pushAfterBusy");

        // Randomised mix of all opcodes with occasional stalls.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [31:0] b;
            int          sAt, sLen;
            op   = 2'($urandom_range(0, 3));
            b    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5));
            sAt  = 0;
            sLen = 0;
            if ($urandom_range(0, 2) == 0) begin
                sAt  = $urandom_range(0, 7);
                sLen = $urandom_range(1, 3);
            end
            applyStimulus(op, $urandom, b, sAt, sLen, "random");
        end
        waitIdle();
        repeat (3) begin @(posedge clk); #1; end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ci_fir_engine.md
# ci_fir_engine

Parametrised Nios II multi-cycle custom-instruction FIR engine with a run-time-loadable coefficient bank, a sample delay line and a sequential multiply-accumulate datapath. It is the next generation of the fixed-latency FIR custom instruction. `done` is derived from the real datapath state rather than a fixed latency counter. The opcode on `n` selects coefficient load, sample push/filter, clear, or read-back of the last result. The block sits on the CPU custom-instruction port beside the other CI_* accelerators.

## Interface
- TAPS, 16: filter length, 2..64.
- DATA_W, 9: signed sample width, taken from dataa[DATA_W-1:0].
- COEF_W, 12: signed coefficient width, taken from dataa[COEF_W-1:0].
- SHIFT, 0: arithmetic right shift applied to the accumulator before output.
- Elaboration constraint: ACC_W = DATA_W+COEF_W+clog2(TAPS) must be ≤ 32; elaboration fails otherwise.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  CPU clock enable; all state frozen while low
- start  in  1  one-cycle instruction strobe, qualified by clk_en
- n  in  2  opcode: 0 LOAD_COEF, 1 PUSH, 2 CLEAR, 3 READ_LAST
- dataa  in  32  coefficient (LOAD_COEF) or sample (PUSH)
- datab  in  32  coefficient index (LOAD_COEF); ignored otherwise
- result  out  32  instruction result, valid while done=1, held otherwise
- done  out  1  single-cycle completion pulse

## Operation
- States are IDLE, MAC and FIN. All state advances only on cycles with clk_en=1.
- **IDLE, start with n=0 (LOAD_COEF):**
  - If datab < TAPS: coef[datab] <= dataa[COEF_W-1:0] and result <= 0.
  - Otherwise: no write, and result <= 32'hFFFF_FFFF as the error flag.
  - Stay in IDLE and pulse done next cycle.
- **IDLE, start with n=1 (PUSH):**
  - Shift the delay line: x[k] <= x[k-1], and x[0] <= the sign-extended new sample.
  - acc <= 0, idx <= 0, then go to MAC.
- **MAC:** each cycle, acc += x[idx]*coef[idx] with signed full-precision arithmetic and idx++. After the idx = TAPS-1 product, go to FIN.
- **FIN:**
  - result <= sign-extend(acc >>> SHIFT) to 32 bits.
  - last <= the same value.
  - Pulse done, then return to IDLE.
- **IDLE, start with n=2 (CLEAR):** zero the delay line (coefficients are kept), result <= 0, pulse done.
- **IDLE, start with n=3 (READ_LAST):** result <= last, pulse done.
- **start while in MAC or FIN:** ignored; the in-flight operation completes unaffected.
- **Reset:**
  - Clears coef, the delay line, acc, idx and last, and sets state to IDLE.
  - Drives result=0 and done=0.
  - Reset mid-MAC aborts the operation with no done pulse.
- **clk_en low mid-operation:** state, idx, acc and done are held. done is gated (done output = done_reg & clk_en), so any pulse is delivered on the next enabled cycle.

## Timing
- All latencies are counted in clk_en-qualified cycles after the start edge.
- LOAD_COEF, CLEAR and READ_LAST: done is high in the cycle immediately after start (latency 1).
- PUSH: done is high at latency TAPS+2.
  - 1 cycle for shift, TAPS MAC cycles, and 1 FIN cycle minus overlap.
  - Exactly TAPS+2 for the default configuration.
- A new start is accepted in the cycle done is high.
- done is high for exactly one enabled cycle per accepted start.
- result changes only on the cycle done rises.
- A coefficient loaded by LOAD_COEF is used by any PUSH started on or after the cycle of its done.

## Structure
- Package ci_fir_pkg holds:
  - Opcode localparams OP_LOAD_COEF, OP_PUSH, OP_CLEAR and OP_READ_LAST.
  - The state enum IDLE/MAC/FIN.
  - An ACC_W helper function.
- One sub-module, ci_fir_mac:
  - Registered signed DATA_W×COEF_W multiply feeding an ACC_W accumulator.
  - Clear and enable inputs.
- The top level contains the FSM, the coefficient/delay-line register arrays and the index mux.

## Test plan
All scenarios use TAPS=4, SHIFT=0 unless stated.
- **Reset:** assert reset mid-PUSH (MAC state), then release -> done never pulses; result=0; READ_LAST returns 0; subsequent PUSH of 5 returns 0, since coefficients were cleared.
- **Basic filter:** LOAD_COEF [1,2,3,4] at idx 0..3, then PUSH 1, 2, 3 -> results 1, 4, 10. Each PUSH done arrives exactly 6 enabled cycles after start.
- **Signed extremes:** LOAD_COEF all taps -2048, then PUSH -256 four times -> 2,097,152 (32'h0020_0000). With SHIFT=4 -> 131,072.
- **Bad index and clear:** LOAD_COEF with datab=7 -> result 32'hFFFF_FFFF, coefficients unchanged. CLEAR then PUSH 0 -> result 0, and READ_LAST returns 0.
- **clk_en stall:**
  - Drop clk_en for 3 cycles during MAC -> done is delayed by exactly 3 clk cycles, is high once, and the result is unchanged.
  - clk_en low in the would-be done cycle -> done appears on the next enabled cycle.
- **Busy start:** issue a second start (n=2) during MAC -> it is ignored, the delay line is not cleared, a single done is seen, and the PUSH result is correct.
